// File: rtl/pool_requant_drain.sv
// Channel-ordered drain of K pooled accumulator streams with requantization
// (optional ReLU, round-half-up arithmetic shift, signed saturation).
module pool_requant_drain #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned K     = 6,
    localparam int unsigned CW   = (K > 1) ? $clog2(K) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_async_i,
    input  logic [4:0]              shift_i,
    input  logic                    relu_en_i,
    input  logic [31:0]             frame_pixels_i,
    input  logic [K-1:0]            valid_i,
    output logic [K-1:0]            ready_o,
    input  logic signed [WIDTH-1:0] data_i [K],
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [OUT_W-1:0]        m_data_o,
    output logic [CW-1:0]           m_chan_o,
    output logic                    m_eop_o,
    output logic                    m_eof_o
);

    // Wide enough that x + 2^(shift-1) can never overflow for any shift.
    localparam int unsigned EXT_W = WIDTH + 33;
    localparam logic [CW-1:0] LAST_CH = CW'(K - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [CW-1:0]  ch_idx;
    logic [31:0]    pix_cnt;
    logic [4:0]     cfg_shift;
    logic           cfg_relu;
    logic [31:0]    cfg_pixels;

    logic                    at_boundary_c;
    logic [4:0]              eff_shift_c;
    logic                    eff_relu_c;
    logic [31:0]             eff_pixels_c;
    logic                    adv_c;
    logic                    sel_valid_c;
    logic signed [WIDTH-1:0] sel_data_c;
    logic                    accept_c;
    logic                    eop_c;
    logic                    eof_c;

    logic signed [EXT_W-1:0] x_ext_c;
    logic signed [EXT_W-1:0] bias_c;
    logic signed [EXT_W-1:0] biased_c;
    logic signed [EXT_W-1:0] shifted_c;
    logic [OUT_W-1:0]        q_c;

    // At a frame boundary the live inputs apply immediately, so the first
    // accept of a frame already sees the configuration being captured.
    assign at_boundary_c = (ch_idx == '0) && (pix_cnt == '0);
    assign eff_shift_c   = at_boundary_c ? shift_i        : cfg_shift;
    assign eff_relu_c    = at_boundary_c ? relu_en_i      : cfg_relu;
    assign eff_pixels_c  = at_boundary_c ? frame_pixels_i : cfg_pixels;

    assign adv_c = !m_valid_o || m_ready_i;

    // Only the current channel is offered ready; valid_i does not feed back.
    always_comb begin
        ready_o = '0;
        for (int k = 0; k < int'(K); k++) begin
            ready_o[k] = adv_c && !rst_async_i && (ch_idx == CW'(k));
        end
    end

    always_comb begin
        sel_valid_c = 1'b0;
        sel_data_c  = '0;
        for (int k = 0; k < int'(K); k++) begin
            if (ch_idx == CW'(k)) begin
                sel_valid_c = valid_i[k];
                sel_data_c  = data_i[k];
            end
        end
    end

    assign accept_c = sel_valid_c && adv_c;
    assign eop_c    = (ch_idx == LAST_CH);
    assign eof_c    = eop_c && (pix_cnt == (eff_pixels_c - 32'd1));

    // Requantize: ReLU, rounding shift, saturate.
    always_comb begin
        x_ext_c = {{(EXT_W - WIDTH){sel_data_c[WIDTH-1]}}, sel_data_c};
        if (eff_relu_c && sel_data_c[WIDTH-1]) begin
            x_ext_c = '0;
        end
        bias_c = '0;
        if (eff_shift_c != 5'd0) begin
            bias_c = EXT_W'(1) << (eff_shift_c - 5'd1);
        end
        biased_c  = x_ext_c + bias_c;
        shifted_c = biased_c >>> eff_shift_c;
        if (shifted_c > SAT_MAX) begin
            q_c = SAT_MAX[OUT_W-1:0];
        end else if (shifted_c < SAT_MIN) begin
            q_c = SAT_MIN[OUT_W-1:0];
        end else begin
            q_c = shifted_c[OUT_W-1:0];
        end
    end

    // Channel / pixel position and frame configuration.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            ch_idx     <= '0;
            pix_cnt    <= '0;
            cfg_shift  <= '0;
            cfg_relu   <= 1'b0;
            cfg_pixels <= '0;
        end else begin
            if (at_boundary_c) begin
                cfg_shift  <= shift_i;
                cfg_relu   <= relu_en_i;
                cfg_pixels <= frame_pixels_i;
            end
            if (accept_c) begin
                if (eop_c) begin
                    ch_idx  <= '0;
                    pix_cnt <= eof_c ? 32'd0 : (pix_cnt + 32'd1);
                end else begin
                    ch_idx  <= ch_idx + CW'(1);
                end
            end
        end
    end

    // Output register; holds everything while the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_chan_o  <= '0;
            m_eop_o   <= 1'b0;
            m_eof_o   <= 1'b0;
        end else if (adv_c) begin
            m_valid_o <= accept_c;
            if (accept_c) begin
                m_data_o <= q_c;
                m_chan_o <= ch_idx;
                m_eop_o  <= eop_c;
                m_eof_o  <= eof_c;
            end
        end
    end

endmodule

// File: tb/tb_pool_requant_drain.sv
// Randomized self-checking bench for pool_requant_drain against a
// real-arithmetic requantization model and an ordered sample queue.
module tb_pool_requant_drain;

    localparam int K     = 6;
    localparam int WIDTH = 24;
    localparam int OUT_W = 8;
    localparam int CW    = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [4:0]              shift_i = '0;
    logic                    relu_en_i = 1'b0;
    logic [31:0]             frame_pixels_i = 32'd1;
    logic [K-1:0]            valid_i = '0;
    logic [K-1:0]            ready_o;
    logic signed [WIDTH-1:0] data_i [K];
    logic                    m_valid_o;
    logic                    m_ready_i = 1'b0;
    logic [OUT_W-1:0]        m_data_o;
    logic [CW-1:0]           m_chan_o;
    logic                    m_eop_o;
    logic                    m_eof_o;

    always #5 clk = ~clk;

    pool_requant_drain #(.WIDTH(WIDTH), .OUT_W(OUT_W), .K(K)) dut (
        .clk_i(clk), .rst_async_i(rst), .shift_i(shift_i), .relu_en_i(relu_en_i),
        .frame_pixels_i(frame_pixels_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_chan_o(m_chan_o), .m_eop_o(m_eop_o), .m_eof_o(m_eof_o)
    );

    typedef struct { logic [12:0] w; int cyc; } cap_t;

    int   seq[$];
    cap_t cap[$];
    int   acc_cnt, cyc, first_acc_cyc;
    int   rdy_viol, hold_viol;
    int   chg_at_acc = -1, chg_shift;
    bit   vrand;
    int   rmode;
    bit   prev_stall;
    logic [12:0] prev_w;
    int   pass_cnt, tot_cnt;

    function automatic logic [12:0] pack_out();
        return {m_data_o, m_chan_o, m_eop_o, m_eof_o};
    endfunction

    // Round half up == floor(x / 2^s + 0.5), then clamp to int8.
    function automatic int ref_q(int x, int s, bit relu);
        real d, v;
        longint r;
        d = 1.0;
        for (int i = 0; i < s; i++) d = d * 2.0;
        if (relu && x < 0) x = 0;
        v = $floor(real'(x) / d + 0.5);
        r = longint'(v);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    function automatic logic [12:0] exp_w(int x, int s, bit relu, int i, int pixels);
        int ch;
        bit eop, eof;
        ch  = i % K;
        eop = (ch == K - 1);
        eof = eop && (((i / K) % pixels) == pixels - 1);
        return {8'(ref_q(x, s, relu)), 3'(ch), eop, eof};
    endfunction

    function automatic int rnd_val();
        logic [23:0] t;
        case ($urandom % 3)
            0: return int'($urandom_range(0, 600)) - 300;
            1: begin t = 24'($urandom); return int'($signed(t)); end
            default: return ($urandom % 2) ? 8388607 : -8388608;
        endcase
    endfunction

    // One clock: upstream offers the next sample of every channel, consumer
    // ready per rmode; observes handshakes and protocol invariants.
    task automatic cycle();
        int cur, off, k_acc, c;
        bit mr;
        logic [K-1:0] exp_r;
        @(negedge clk);
        cur = acc_cnt % K;
        if (chg_at_acc >= 0 && acc_cnt >= chg_at_acc) shift_i = 5'(chg_shift);
        case (rmode)
            0: mr = 1'b1;
            1: mr = ($urandom % 3) != 0;
            default: mr = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
        m_ready_i = mr;
        for (int k = 0; k < K; k++) begin
            off = (k - cur + K) % K;
            if (off < seq.size() && (!vrand || ($urandom % 4) != 0)) begin
                valid_i[k] = 1'b1;
                data_i[k]  = WIDTH'(seq[off]);
            end else begin
                valid_i[k] = 1'b0;
                data_i[k]  = WIDTH'($urandom);
            end
        end
        #1;
        c = cyc;
        if (prev_stall && (!m_valid_o || pack_out() !== prev_w)) hold_viol++;
        exp_r = (m_valid_o && !m_ready_i) ? '0 : (K'(1) << cur);
        if (ready_o !== exp_r) rdy_viol++;
        if (m_valid_o && m_ready_i) cap.push_back('{pack_out(), c});
        prev_stall = m_valid_o && !m_ready_i;
        prev_w     = pack_out();
        k_acc = -1;
        for (int k = 0; k < K; k++) if (valid_i[k] && ready_o[k]) k_acc = k;
        @(posedge clk);
        cyc++;
        if (k_acc >= 0) begin
            if (k_acc != cur) rdy_viol++;
            if (acc_cnt == 0) first_acc_cyc = c;
            void'(seq.pop_front());
            acc_cnt++;
        end
    endtask

    task automatic run(input int n_exp, input int budget);
        for (int i = 0; i < budget && cap.size() < n_exp; i++) cycle();
    endtask

    task automatic clear_model();
        seq.delete();
        cap.delete();
        acc_cnt    = 0;
        prev_stall = 1'b0;
        rdy_viol   = 0;
        hold_viol  = 0;
        chg_at_acc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        valid_i   = '0;
        m_ready_i = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        valid_i   = '1;
        m_ready_i = 1'b1;
        #1;
        tot_cnt++; if (m_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid_o); else pass_cnt++;
        tot_cnt++; if (m_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", m_data_o); else pass_cnt++;
        tot_cnt++; if (m_chan_o !== 3'd0) $display("FAIL reset_chan: got %0d want 0", m_chan_o); else pass_cnt++;
        tot_cnt++; if ({m_eop_o, m_eof_o} !== 2'b00) $display("FAIL reset_eop_eof: got %b want 00", {m_eop_o, m_eof_o}); else pass_cnt++;
        tot_cnt++; if (ready_o !== 6'b0) $display("FAIL reset_ready: got %b want 000000", ready_o); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        valid_i = '0;
        rst     = 1'b0;
        #1;
        tot_cnt++; if (ready_o !== 6'b000001) $display("FAIL reset_release_ready: got %b want 000001", ready_o); else pass_cnt++;
    endtask

    task automatic test_order();
        int in[$];
        do_reset();
        shift_i = 5'd8; relu_en_i = 1'b0; frame_pixels_i = 32'd100;
        rmode = 0; vrand = 1'b0;
        for (int i = 0; i < K; i++) begin in.push_back(i * 256); seq.push_back(i * 256); end
        run(K, 50);
        tot_cnt++; if (cap.size() != K) $display("FAIL order_count: got %0d want %0d", cap.size(), K); else pass_cnt++;
        for (int i = 0; i < cap.size(); i++) begin
            tot_cnt++; if (cap[i].w !== exp_w(in[i], 8, 1'b0, i, 100)) $display("FAIL order_word[%0d]: got %h want %h", i, cap[i].w, exp_w(in[i], 8, 1'b0, i, 100)); else pass_cnt++;
            tot_cnt++; if (cap[i].cyc != first_acc_cyc + 1 + i) $display("FAIL order_timing[%0d]: got cycle %0d want %0d", i, cap[i].cyc, first_acc_cyc + 1 + i); else pass_cnt++;
        end
        tot_cnt++; if (rdy_viol != 0) $display("FAIL order_ready: got %0d violations want 0", rdy_viol); else pass_cnt++;
    endtask

    task automatic test_round_sat();
        int in[6]  = '{24, 23, -24, 4000, -4000, -8};
        int exp[6] = '{2, 1, -1, 127, -128, 0};
        do_reset();
        shift_i = 5'd4; relu_en_i = 1'b0; frame_pixels_i = 32'd100;
        rmode = 0; vrand = 1'b0;
        for (int i = 0; i < 6; i++) seq.push_back(in[i]);
        run(6, 50);
        tot_cnt++; if (cap.size() != 6) $display("FAIL roundsat_count: got %0d want 6", cap.size()); else pass_cnt++;
        for (int i = 0; i < cap.size(); i++) begin
            tot_cnt++; if (cap[i].w[12:5] !== 8'(exp[i])) $display("FAIL roundsat_data[%0d]: got %0d want %0d", i, $signed(cap[i].w[12:5]), exp[i]); else pass_cnt++;
        end
    endtask

    task automatic test_relu();
        int in[6]  = '{-5, 0, 100, 300, -200, 127};
        int exp[6] = '{0, 0, 100, 127, 0, 127};
        do_reset();
        shift_i = 5'd0; relu_en_i = 1'b1; frame_pixels_i = 32'd100;
        rmode = 0; vrand = 1'b0;
        for (int i = 0; i < 6; i++) seq.push_back(in[i]);
        run(6, 50);
        tot_cnt++; if (cap.size() != 6) $display("FAIL relu_count: got %0d want 6", cap.size()); else pass_cnt++;
        for (int i = 0; i < cap.size(); i++) begin
            tot_cnt++; if (cap[i].w[12:5] !== 8'(exp[i])) $display("FAIL relu_data[%0d]: got %0d want %0d", i, $signed(cap[i].w[12:5]), exp[i]); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int in[$];
        int v;
        do_reset();
        shift_i = 5'd0; relu_en_i = 1'b0; frame_pixels_i = 32'd100;
        rmode = 2; vrand = 1'b0;
        for (int i = 0; i < 2 * K; i++) begin
            v = int'($urandom_range(0, 200)) - 100;
            in.push_back(v); seq.push_back(v);
        end
        run(2 * K, 200);
        tot_cnt++; if (cap.size() != 2 * K) $display("FAIL bp_count: got %0d want %0d", cap.size(), 2 * K); else pass_cnt++;
        for (int i = 0; i < cap.size(); i++) begin
            tot_cnt++; if (cap[i].w !== exp_w(in[i], 0, 1'b0, i, 100)) $display("FAIL bp_word[%0d]: got %h want %h", i, cap[i].w, exp_w(in[i], 0, 1'b0, i, 100)); else pass_cnt++;
        end
        tot_cnt++; if (rdy_viol != 0) $display("FAIL bp_ready: got %0d violations want 0", rdy_viol); else pass_cnt++;
        tot_cnt++; if (hold_viol != 0) $display("FAIL bp_hold: got %0d violations want 0", hold_viol); else pass_cnt++;
    endtask

    task automatic test_frame();
        int in[$];
        int v, s;
        do_reset();
        shift_i = 5'd2; relu_en_i = 1'b0; frame_pixels_i = 32'd2;
        rmode = 1; vrand = 1'b1;
        chg_at_acc = 3; chg_shift = 3;
        for (int i = 0; i < 4 * K; i++) begin v = rnd_val(); in.push_back(v); seq.push_back(v); end
        run(4 * K, 400);
        tot_cnt++; if (cap.size() != 4 * K) $display("FAIL frame_count: got %0d want %0d", cap.size(), 4 * K); else pass_cnt++;
        for (int i = 0; i < cap.size(); i++) begin
            s = (i < 2 * K) ? 2 : 3;
            tot_cnt++; if (cap[i].w !== exp_w(in[i], s, 1'b0, i, 2)) $display("FAIL frame_word[%0d]: got %h want %h", i, cap[i].w, exp_w(in[i], s, 1'b0, i, 2)); else pass_cnt++;
        end
        tot_cnt++; if (rdy_viol != 0 || hold_viol != 0) $display("FAIL frame_protocol: got %0d/%0d violations want 0/0", rdy_viol, hold_viol); else pass_cnt++;
    endtask

    task automatic test_random();
        int in[$];
        int v, s, px, n;
        bit rl;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            in.delete();
            s  = (r == 0) ? int'($urandom_range(24, 31)) : int'($urandom % 32);
            rl = 1'($urandom);
            px = int'($urandom_range(1, 3));
            shift_i = 5'(s); relu_en_i = rl; frame_pixels_i = 32'(px);
            rmode = 1; vrand = 1'b1;
            n = 3 * K;
            for (int i = 0; i < n; i++) begin v = rnd_val(); in.push_back(v); seq.push_back(v); end
            run(n, 600);
            tot_cnt++; if (cap.size() != n) $display("FAIL rand%0d_count: got %0d want %0d", r, cap.size(), n); else pass_cnt++;
            for (int i = 0; i < cap.size(); i++) begin
                tot_cnt++; if (cap[i].w !== exp_w(in[i], s, rl, i, px)) $display("FAIL rand%0d_word[%0d]: got %h want %h", r, i, cap[i].w, exp_w(in[i], s, rl, i, px)); else pass_cnt++;
            end
            tot_cnt++; if (rdy_viol != 0 || hold_viol != 0) $display("FAIL rand%0d_protocol: got %0d/%0d violations want 0/0", r, rdy_viol, hold_viol); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int in[$];
        do_reset();
        shift_i = 5'd0; relu_en_i = 1'b0; frame_pixels_i = 32'd2;
        rmode = 0; vrand = 1'b0;
        for (int i = 0; i < 2 * K; i++) seq.push_back(i + 1);
        for (int i = 0; i < 100 && acc_cnt < K + 3; i++) cycle();
        tot_cnt++; if (m_valid_o !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", m_valid_o); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        tot_cnt++; if (m_valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", m_valid_o); else pass_cnt++;
        tot_cnt++; if (pack_out() !== 13'h0) $display("FAIL rstmid_outputs: got %h want 0000", pack_out()); else pass_cnt++;
        tot_cnt++; if (ready_o !== 6'b0) $display("FAIL rstmid_ready: got %b want 000000", ready_o); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        valid_i = '0;
        m_ready_i = 1'b1;
        clear_model();
        #1;
        tot_cnt++; if (ready_o !== 6'b000001) $display("FAIL rstmid_release_ready: got %b want 000001", ready_o); else pass_cnt++;
        for (int i = 0; i < 2 * K; i++) begin in.push_back(100 + i); seq.push_back(100 + i); end
        run(2 * K, 100);
        tot_cnt++; if (cap.size() != 2 * K) $display("FAIL rstmid_count: got %0d want %0d", cap.size(), 2 * K); else pass_cnt++;
        for (int i = 0; i < cap.size(); i++) begin
            tot_cnt++; if (cap[i].w !== exp_w(in[i], 0, 1'b0, i, 2)) $display("FAIL rstmid_word[%0d]: got %h want %h", i, cap[i].w, exp_w(in[i], 0, 1'b0, i, 2)); else pass_cnt++;
        end
    endtask

    initial begin
        for (int k = 0; k < K; k++) data_i[k] = '0;
        pass_cnt = 0;
        tot_cnt  = 0;
        cyc      = 0;
        test_reset();
        test_order();
        test_round_sat();
        test_relu();
        test_backpressure();
        test_frame();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
